prefix_adder_stim_checker: RTL and testbench
============================================

PREFIX_ADDER_STIM_CHECKER -- requirements
Module: prefix_adder_stim_checker

Interface
REQ-001 Parameter WIDTH, default 4: operand width of the adder under test, legal range 1..16.
REQ-002 Parameter LATENCY, default 2: cycles from a_out/b_out to dut_sum/dut_cout, which matches the registered adder wrappers; legal range 1..8.
REQ-003 Parameter NUM_VECTORS, default 256: vectors per run, legal range 2..65535.
REQ-004 Parameter SEED, default 32'hACE10001: LFSR reset value, must be nonzero.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle run request.
REQ-008 a_out, b_out  output  WIDTH  operands driven to the adder wrapper's a and b inputs.
REQ-009 dut_sum  input  WIDTH; dut_cout  input  1  adder wrapper's sum and cout results.
REQ-010 busy  output  1  run in progress.
REQ-011 done  output  1  run complete.
REQ-012 pass  output  1  run completed with zero mismatches.
REQ-013 err_count  output  16  mismatch count, saturating.
REQ-014 vec_count  output  16  number of vectors compared.
REQ-015 fail_a, fail_b  output  WIDTH; fail_exp  output  WIDTH+1  first-failure capture (see Configuration).

Function
REQ-016 FSM states and transitions:
- IDLE to RUN on start.
- RUN to DRAIN after NUM_VECTORS issue cycles.
- DRAIN to DONE after LATENCY cycles.
- DONE to RUN on start.
REQ-017 RUN issues exactly one vector per cycle on a_out/b_out; there is no stall.
REQ-018 Vector 0 is a=all-ones, b=1; vector 1 is a=all-ones, b=all-ones. Vectors 2 onward are the low 2*WIDTH bits of a 32-bit Galois LFSR (taps 32,22,2,1): a is the low WIDTH bits, b is the next WIDTH bits. The LFSR advances once per issued vector from vector 2 onward.
REQ-019 Expected value = a + b computed at WIDTH+1 bits, with cout as the MSB. It travels through a LATENCY-deep shift register together with a valid bit.
REQ-020 When the valid bit emerges, the block compares {dut_cout, dut_sum} with the expected value and increments vec_count. It also increments err_count on mismatch, saturating at 16'hFFFF.
REQ-021 Outside RUN, a_out and b_out hold 0 and no valid bits enter the pipeline.
REQ-022 busy is high in RUN and DRAIN only.
REQ-023 done is high in DONE only. pass = done AND (err_count == 0).
REQ-024 start in RUN or DRAIN is ignored.
REQ-025 start in DONE clears err_count, vec_count and the capture registers, and reloads the LFSR with SEED before the first issue.
REQ-026 err_count and vec_count hold their values in DONE until the next start.
REQ-027 Timing: with start high at edge T, vector 0 is on a_out in the cycle after T. done rises NUM_VECTORS+LATENCY cycles after that cycle.

Reset
REQ-028 rst forces IDLE and loads the LFSR with SEED. It clears all pipeline valid bits, so in-flight vectors are discarded.
REQ-029 rst drives the following outputs to 0: a_out, b_out, busy, done, pass, err_count, vec_count, fail_a, fail_b, fail_exp.
REQ-030 rst asserted mid-run aborts the run; no compare occurs in the cycle after rst.

Configuration
REQ-031 Macro CHECKER_FIRST_ERR_CAPTURE_EN:
- Defined: on the first mismatch of a run, latch the failing a, b and expected value into fail_a, fail_b and fail_exp, and hold them until the next start or rst.
- Undefined: fail_a, fail_b and fail_exp are tied to 0 and no capture registers exist.

Verification
REQ-032 Correct registered adder, WIDTH=4, LATENCY=2, NUM_VECTORS=16, one start pulse -> done 18 cycles after vector 0; pass=1, vec_count=16, err_count=0.
REQ-033 Model forcing cout=0 -> vector 0 (15+1=16) and vector 1 (15+15=30) both mismatch; err_count>=2; pass=0. With the macro defined: fail_a=15, fail_b=1, fail_exp=5'h10.
REQ-034 rst pulsed 5 cycles into a run -> all outputs 0 the next cycle; a new start produces the same vector sequence as a fresh run.
REQ-035 start held high for the whole run -> exactly one run of 16 vectors; once in DONE, the still-high start launches the second run.
REQ-036 Model with sum always inverted, NUM_VECTORS=65535, WIDTH=16 -> err_count=65535; vec_count=65535; pass=0.

Source files
------------

// File: rtl/prefix_adder_stim_checker.sv
// ---------------------------------------------------------------------------
// prefix_adder_stim_checker
//
// Drives operand vectors into an external registered adder and checks that
// adder's results. It issues one vector per cycle for NUM_VECTORS cycles.
// Vectors 0 and 1 are fixed carry-stress patterns. The remaining vectors come
// from a 32-bit Galois LFSR (taps 32,22,2,1). The expected a+b result travels
// through a LATENCY-deep shift register alongside a valid bit. When it
// emerges, it is compared with {dut_cout, dut_sum}.
//
// Parameters
//   WIDTH        operand width of the adder under test (1..16)
//   LATENCY      cycles from a_out/b_out to dut_sum/dut_cout (1..8)
//   NUM_VECTORS  vectors per run (2..65535)
//   SEED         LFSR reload value (nonzero)
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   run request (honoured in IDLE and DONE only)
//   a_out      out  [WIDTH]    operand a to the adder
//   b_out      out  [WIDTH]    operand b to the adder
//   dut_sum    in   [WIDTH]    adder sum
//   dut_cout   in   1          adder carry out
//   busy       out  high in RUN and DRAIN
//   done       out  high in DONE
//   pass       out  done with zero mismatches
//   err_count  out  [16]       saturating mismatch count
//   vec_count  out  [16]       vectors compared
//   fail_a     out  [WIDTH]    first failing operand a
//   fail_b     out  [WIDTH]    first failing operand b
//   fail_exp   out  [WIDTH+1]  first failing expected value
//
// Optional feature: define CHECKER_FIRST_ERR_CAPTURE_EN to latch the first
// mismatch of a run into fail_a/fail_b/fail_exp. When the macro is undefined,
// those outputs are tied to 0.
// ---------------------------------------------------------------------------
module prefix_adder_stim_checker #(
  parameter int          WIDTH       = 4,
  parameter int          LATENCY     = 2,
  parameter int          NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = 32'hACE10001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      vec_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH:0]   fail_exp
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);
  localparam logic [3:0]  LAST_DRAIN = 4'(LATENCY - 1);
  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;

  function automatic logic [15:0] f_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] f_lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'd0);
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [15:0]        r_idx;
  logic [3:0]         r_drain;
  logic [31:0]        r_lfsr;
  logic [15:0]        r_err_cnt;
  logic [15:0]        r_vec_cnt;
  logic [LATENCY-1:0] r_vld_pipe;
  logic [WIDTH:0]     r_exp_pipe [LATENCY];

  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH:0]     w_exp;
  logic [WIDTH:0]     w_obs;
  logic               w_issue;
  logic               w_start_run;
  logic               w_cmp;
  logic               w_mismatch;

  assign w_issue     = (r_state == S_RUN);
  // start is only honoured where a new run may begin
  assign w_start_run = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (r_idx == LAST_IDX) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_drain == LAST_DRAIN) w_state_nxt = S_DONE;
      S_DONE:  if (start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Vector selection: two fixed carry-stress vectors, then LFSR bits
  always_comb begin
    w_a = '0;
    w_b = '0;
    if (w_issue) begin
      case (r_idx)
        16'd0: begin
          w_a = {WIDTH{1'b1}};
          w_b = WIDTH'(1);
        end
        16'd1: begin
          w_a = {WIDTH{1'b1}};
          w_b = {WIDTH{1'b1}};
        end
        default: begin
          w_a = r_lfsr[WIDTH-1:0];
          w_b = r_lfsr[2*WIDTH-1:WIDTH];
        end
      endcase
    end
  end

  assign w_exp      = {1'b0, w_a} + {1'b0, w_b};
  assign w_obs      = {dut_cout, dut_sum};
  assign w_cmp      = r_vld_pipe[LATENCY-1];
  assign w_mismatch = w_cmp && (w_obs != r_exp_pipe[LATENCY-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_drain    <= '0;
      r_lfsr     <= SEED;
      r_err_cnt  <= '0;
      r_vec_cnt  <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_start_run) begin
        r_idx  <= '0;
        r_lfsr <= SEED;
      end else if (w_issue) begin
        r_idx <= r_idx + 16'd1;
        // vectors 0 and 1 are fixed, so the LFSR first moves after vector 2
        if (r_idx >= 16'd2) r_lfsr <= f_lfsr_step(r_lfsr);
      end

      r_drain <= (r_state == S_DRAIN) ? r_drain + 4'd1 : 4'd0;

      // The pipeline is empty whenever a run can start, so clearing and
      // counting never collide.
      if (w_start_run) begin
        r_err_cnt <= '0;
        r_vec_cnt <= '0;
      end else if (w_cmp) begin
        r_vec_cnt <= r_vec_cnt + 16'd1;
        if (w_mismatch) r_err_cnt <= f_sat_inc(r_err_cnt);
      end

      r_vld_pipe[0] <= w_issue;
      for (int i = 1; i < LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
    end
  end

  // Expected-value pipeline: stage 0 holds the vector issued last cycle
  always_ff @(posedge clk) begin
    r_exp_pipe[0] <= w_exp;
    for (int i = 1; i < LATENCY; i++) r_exp_pipe[i] <= r_exp_pipe[i-1];
  end

`ifdef CHECKER_FIRST_ERR_CAPTURE_EN
  logic [WIDTH-1:0] r_a_pipe [LATENCY];
  logic [WIDTH-1:0] r_b_pipe [LATENCY];
  logic [WIDTH-1:0] r_fail_a;
  logic [WIDTH-1:0] r_fail_b;
  logic [WIDTH:0]   r_fail_exp;
  logic             r_cap_done;

  // Operand pipeline: operands aligned with r_exp_pipe
  always_ff @(posedge clk) begin
    r_a_pipe[0] <= w_a;
    r_b_pipe[0] <= w_b;
    for (int i = 1; i < LATENCY; i++) begin
      r_a_pipe[i] <= r_a_pipe[i-1];
      r_b_pipe[i] <= r_b_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fail_a   <= '0;
      r_fail_b   <= '0;
      r_fail_exp <= '0;
      r_cap_done <= 1'b0;
    end else if (w_start_run) begin
      r_fail_a   <= '0;
      r_fail_b   <= '0;
      r_fail_exp <= '0;
      r_cap_done <= 1'b0;
    end else if (w_mismatch && !r_cap_done) begin
      r_fail_a   <= r_a_pipe[LATENCY-1];
      r_fail_b   <= r_b_pipe[LATENCY-1];
      r_fail_exp <= r_exp_pipe[LATENCY-1];
      r_cap_done <= 1'b1;
    end
  end

  assign fail_a   = r_fail_a;
  assign fail_b   = r_fail_b;
  assign fail_exp = r_fail_exp;
`else
  assign fail_a   = '0;
  assign fail_b   = '0;
  assign fail_exp = '0;
`endif

  assign a_out     = w_a;
  assign b_out     = w_b;
  assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);
  assign pass      = (r_state == S_DONE) && (r_err_cnt == 16'd0);
  assign err_count = r_err_cnt;
  assign vec_count = r_vec_cnt;

endmodule

// File: tb/tb_prefix_adder_stim_checker.sv
// ---------------------------------------------------------------------------
// Bench for prefix_adder_stim_checker.
//   dut  : WIDTH=4, LATENCY=2, NUM_VECTORS=16. It is paired with a two-stage
//          registered adder that can run correctly, with cout forced to 0,
//          or with the sum inverted.
//   dut2 : WIDTH=16, LATENCY=2, NUM_VECTORS=65535. It is paired with an adder
//          whose sum is always inverted. This run proceeds in parallel with
//          the other tests.
// Expected vectors are queued when start is driven and popped each issue cycle.
// ---------------------------------------------------------------------------
module tb_prefix_adder_stim_checker;

  localparam int          W    = 4;
  localparam int          L    = 2;
  localparam int          N    = 16;
  localparam int          W2   = 16;
  localparam int          N2   = 65535;
  localparam logic [31:0] SEED = 32'hACE10001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, rst2 = 1'b1, start2 = 1'b0;

  logic [W-1:0]  a1, b1, sum1, fail_a1, fail_b1;
  logic          cout1, busy1, done1, pass1;
  logic [15:0]   err1, vec1;
  logic [W:0]    fail_exp1;

  logic [W2-1:0] a2, b2, sum2, fail_a2, fail_b2;
  logic          cout2, busy2, done2, pass2;
  logic [15:0]   err2, vec2;
  logic [W2:0]   fail_exp2;

  prefix_adder_stim_checker #(.WIDTH(W), .LATENCY(L), .NUM_VECTORS(N), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .a_out(a1), .b_out(b1),
    .dut_sum(sum1), .dut_cout(cout1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .vec_count(vec1), .fail_a(fail_a1), .fail_b(fail_b1),
    .fail_exp(fail_exp1)
  );

  prefix_adder_stim_checker #(.WIDTH(W2), .LATENCY(L), .NUM_VECTORS(N2), .SEED(SEED)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .a_out(a2), .b_out(b2),
    .dut_sum(sum2), .dut_cout(cout2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .vec_count(vec2), .fail_a(fail_a2), .fail_b(fail_b2),
    .fail_exp(fail_exp2)
  );

  // Adder models: two register stages to match LATENCY=2
  int         mode = 0;  // 0 correct, 1 cout forced 0, 2 sum inverted
  logic [W:0]  m1_p0, m1_p1;
  logic [W2:0] m2_p0, m2_p1;

  always_ff @(posedge clk) begin
    m1_p0 <= {1'b0, a1} + {1'b0, b1};
    m1_p1 <= m1_p0;
    m2_p0 <= {1'b0, a2} + {1'b0, b2};
    m2_p1 <= m2_p0;
  end

  always_comb begin
    sum1  = (mode == 2) ? ~m1_p1[W-1:0] : m1_p1[W-1:0];
    cout1 = (mode == 1) ? 1'b0 : m1_p1[W];
    sum2  = ~m2_p1[W2-1:0];
    cout2 = m2_p1[W2];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'h80200003;
    return n;
  endfunction

  logic [2*W-1:0] sb_q[$];  // {a, b}
  int             exp_err;
`ifdef CHECKER_FIRST_ERR_CAPTURE_EN
  logic [W-1:0]   exp_fa, exp_fb;
  logic [W:0]     exp_fexp;
`endif

  // Build the expected vector list and the mismatch count for a fault mode
  task automatic load_vectors(input int fault);
    logic [31:0]  s;
    logic [W-1:0] a, b;
    logic [W:0]   t;
    bit           bad, seen;
    s = SEED;
    seen = 1'b0;
    sb_q.delete();
    exp_err = 0;
`ifdef CHECKER_FIRST_ERR_CAPTURE_EN
    exp_fa = '0; exp_fb = '0; exp_fexp = '0;
`endif
    for (int i = 0; i < N; i++) begin
      if (i == 0) begin
        a = '1; b = W'(1);
      end else if (i == 1) begin
        a = '1; b = '1;
      end else begin
        a = s[W-1:0];
        b = s[2*W-1:W];
        s = lfsr_next(s);
      end
      sb_q.push_back({a, b});
      t = {1'b0, a} + {1'b0, b};
      bad = (fault == 1) ? t[W] : (fault == 2);
      if (bad) begin
        exp_err++;
        if (!seen) begin
          seen = 1'b1;
`ifdef CHECKER_FIRST_ERR_CAPTURE_EN
          exp_fa = a; exp_fb = b; exp_fexp = t;
`endif
        end
      end
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_a_out"}, a1, 0);
    chk({pfx, "_b_out"}, b1, 0);
    chk({pfx, "_busy"}, busy1, 0);
    chk({pfx, "_done"}, done1, 0);
    chk({pfx, "_pass"}, pass1, 0);
    chk({pfx, "_err"}, err1, 0);
    chk({pfx, "_vec"}, vec1, 0);
    chk({pfx, "_fail_a"}, fail_a1, 0);
    chk({pfx, "_fail_b"}, fail_b1, 0);
    chk({pfx, "_fail_exp"}, fail_exp1, 0);
  endtask

  // One run. Without do_start, the caller is already in the vector-0 cycle.
  task automatic run_check(input int fault, input bit do_start, input bit hold);
    logic [2*W-1:0] v;
    mode = fault;
    load_vectors(fault);
    if (do_start) begin
      start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      v = sb_q.pop_front();
      chk("a_out", a1, v[2*W-1:W]);
      chk("b_out", b1, v[W-1:0]);
      chk("busy_run", busy1, 1);
      chk("done_run", done1, 0);
      @(negedge clk);
    end
    for (int j = 0; j < L; j++) begin
      chk("busy_drain", busy1, 1);
      chk("done_drain", done1, 0);
      chk("a_drain", a1, 0);
      @(negedge clk);
    end
    chk("done", done1, 1);
    chk("busy_done", busy1, 0);
    chk("pass", pass1, (exp_err == 0));
    chk("vec_count", vec1, N);
    chk("err_count", err1, exp_err);
    chk("a_done", a1, 0);
`ifdef CHECKER_FIRST_ERR_CAPTURE_EN
    chk("fail_a", fail_a1, exp_fa);
    chk("fail_b", fail_b1, exp_fb);
    chk("fail_exp", fail_exp1, exp_fexp);
`else
    chk("fail_a", fail_a1, 0);
    chk("fail_b", fail_b1, 0);
    chk("fail_exp", fail_exp1, 0);
`endif
  endtask

  initial begin
    logic [2*W-1:0] v;

    // Reset state
    repeat (3) @(negedge clk);
    chk_zero("rst");
    chk("rst2_busy", busy2, 0);
    chk("rst2_vec", vec2, 0);
    rst = 1'b0;
    rst2 = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy1, 0);
    chk("idle_done", done1, 0);

    // Long run on the wide instance, in parallel with the rest
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;

    // Clean run, then cout forced to 0
    run_check(0, 1'b1, 1'b0);
    run_check(1, 1'b1, 1'b0);
    chk("cout0_err_ge2", (err1 >= 16'd2), 1);

    // Counters hold in DONE
    repeat (3) @(negedge clk);
    chk("hold_done", done1, 1);
    chk("hold_err", err1, exp_err);
    chk("hold_vec", vec1, N);

    // A restart from DONE clears the error count and the capture
    run_check(0, 1'b1, 1'b0);

    // Reset 5 cycles into a run
    mode = 0;
    load_vectors(0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      v = sb_q.pop_front();
      chk("abort_a", a1, v[2*W-1:W]);
      chk("abort_b", b1, v[W-1:0]);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk_zero("abort");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_vec_after", vec1, 0);
    chk("abort_busy_after", busy1, 0);
    chk("abort_done_after", done1, 0);
    run_check(0, 1'b1, 1'b0);

    // start held high: one run, then a second run launched from DONE
    run_check(0, 1'b1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    run_check(0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("held_stays_done", done1, 1);
    chk("held_vec", vec1, N);

    // Wait for the wide run, bounded
    for (int k = 0; k < 70000 && !done2; k++) @(negedge clk);
    chk("wide_done", done2, 1);
    chk("wide_err", err2, 16'hFFFF);
    chk("wide_vec", vec2, N2);
    chk("wide_pass", pass2, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
